// File: rtl/controle_preparo.sv
// controle_preparo: coffee-brew sequencer (sensor check, preheat, pump, done / fault latch).
// Optional macro CONTADOR_DOSES_EN adds DOSES, a saturating count of entries into FINALIZA.
module controle_preparo #(
  parameter int T_AQUEC  = 8,
  parameter int T_CURTO  = 4,
  parameter int T_MEDIO  = 8,
  parameter int T_LONGO  = 12,
  parameter int T_VERIF  = 16,
  parameter int T_PRONTO = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] STATUS,
  input  logic       BTN_INICIO,
  input  logic       BTN_CANCELA,
  input  logic [1:0] TAMANHO,
  output logic       TIMER,
  output logic       AQUECE,
  output logic       BOMBA,
  output logic       OCUPADO,
  output logic       PRONTO,
  output logic       ERRO,
  output logic [2:0] CODIGO_ERRO
`ifdef CONTADOR_DOSES_EN
  ,
  output logic [7:0] DOSES
`endif
);

  localparam int MAX_A = (T_AQUEC > T_VERIF) ? T_AQUEC : T_VERIF;
  localparam int MAX_B = (T_PRONTO > MAX_A) ? T_PRONTO : MAX_A;
  localparam int MAX_C = (T_CURTO > MAX_B) ? T_CURTO : MAX_B;
  localparam int MAX_D = (T_MEDIO > MAX_C) ? T_MEDIO : MAX_C;
  localparam int MAX_T = (T_LONGO > MAX_D) ? T_LONGO : MAX_D;
  localparam int CW    = (MAX_T < 2) ? 1 : $clog2(MAX_T);

  localparam logic [CW-1:0] CNT_SAT    = CW'(MAX_T - 1);
  localparam logic [CW-1:0] VERIF_FIM  = CW'(T_VERIF - 1);
  localparam logic [CW-1:0] AQUEC_FIM  = CW'(T_AQUEC - 1);
  localparam logic [CW-1:0] PRONTO_FIM = CW'(T_PRONTO - 1);

  localparam logic [2:0] ST_AGUA     = 3'b001;
  localparam logic [2:0] ST_SENSORES = 3'b100;
  localparam logic [2:0] ST_OK       = 3'b101;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    VERIFICA  = 3'd1,
    AQUECENDO = 3'd2,
    BOMBEANDO = 3'd3,
    FINALIZA  = 3'd4,
    FALHA     = 3'd5
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    tam_q, tam_d;
  logic [2:0]    codigo_q, codigo_d;
  logic [CW-1:0] bomba_fim_s;
  logic          cronometrado_s;
  logic          falha_bomba_s;

  // Last counter value of the pump phase for the latched cup size.
  always_comb begin
    case (tam_q)
      2'b00:   bomba_fim_s = CW'(T_CURTO - 1);
      2'b01:   bomba_fim_s = CW'(T_MEDIO - 1);
      2'b10:   bomba_fim_s = CW'(T_LONGO - 1);
      default: bomba_fim_s = CW'(T_CURTO - 1);
    endcase
  end

  assign falha_bomba_s = (STATUS >= ST_AGUA) && (STATUS <= ST_SENSORES);

  // Next-state logic; cancel is tested first so it beats faults and expiry.
  always_comb begin
    estado_d = estado_q;
    tam_d    = tam_q;
    codigo_d = codigo_q;
    case (estado_q)
      OCIOSO: begin
        if (BTN_INICIO && (TAMANHO != 2'b11)) begin
          estado_d = VERIFICA;
          tam_d    = TAMANHO;
        end else begin
          estado_d = OCIOSO;
        end
      end
      VERIFICA: begin
        if (BTN_CANCELA) begin
          estado_d = OCIOSO;
        end else if (STATUS == ST_OK) begin
          estado_d = AQUECENDO;
        end else if ((STATUS == ST_SENSORES) || (cnt_q == VERIF_FIM)) begin
          estado_d = FALHA;
          codigo_d = STATUS;
        end else begin
          estado_d = VERIFICA;
        end
      end
      AQUECENDO: begin
        if (BTN_CANCELA) begin
          estado_d = OCIOSO;
        end else if (cnt_q == AQUEC_FIM) begin
          estado_d = BOMBEANDO;
        end else begin
          estado_d = AQUECENDO;
        end
      end
      BOMBEANDO: begin
        if (BTN_CANCELA) begin
          estado_d = OCIOSO;
        end else if (falha_bomba_s) begin
          estado_d = FALHA;
          codigo_d = STATUS;
        end else if (cnt_q == bomba_fim_s) begin
          estado_d = FINALIZA;
        end else begin
          estado_d = BOMBEANDO;
        end
      end
      FINALIZA: begin
        if (cnt_q == PRONTO_FIM) begin
          estado_d = OCIOSO;
        end else begin
          estado_d = FINALIZA;
        end
      end
      FALHA: begin
        if (BTN_CANCELA) begin
          estado_d = OCIOSO;
          codigo_d = 3'b000;
        end else begin
          estado_d = FALHA;
        end
      end
      default: begin
        estado_d = OCIOSO;
        codigo_d = 3'b000;
      end
    endcase
  end

  assign cronometrado_s = (estado_q == VERIFICA) || (estado_q == AQUECENDO) ||
                          (estado_q == BOMBEANDO) || (estado_q == FINALIZA);

  // Phase counter: restarts on every transition, counts only in timed phases, saturates.
  always_comb begin
    if (estado_d != estado_q) begin
      cnt_d = '0;
    end else if (cronometrado_s && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, counter, latched size and fault code registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
      tam_q    <= 2'b00;
      codigo_q <= 3'b000;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      tam_q    <= tam_d;
      codigo_q <= codigo_d;
    end
  end

  // Moore output decode; every term comes from registers, so reset clears actuators at once.
  always_comb begin
    TIMER       = ((estado_q == VERIFICA) && (cnt_q == VERIF_FIM)) || (estado_q == FALHA);
    AQUECE      = (estado_q == AQUECENDO) || (estado_q == BOMBEANDO);
    BOMBA       = (estado_q == BOMBEANDO);
    OCUPADO     = cronometrado_s;
    PRONTO      = (estado_q == FINALIZA);
    ERRO        = (estado_q == FALHA);
    CODIGO_ERRO = codigo_q;
  end

`ifdef CONTADOR_DOSES_EN
  logic [7:0] doses_q, doses_d;

  // Count each entry into FINALIZA, holding at 255.
  always_comb begin
    if ((estado_d == FINALIZA) && (estado_q != FINALIZA) && (doses_q != 8'hFF)) begin
      doses_d = doses_q + 8'd1;
    end else begin
      doses_d = doses_q;
    end
  end

  // Dose counter register; cleared only by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      doses_q <= 8'd0;
    end else begin
      doses_q <= doses_d;
    end
  end

  assign DOSES = doses_q;
`endif

endmodule
